// File: rtl/console_writer.sv
// console_writer: byte stream to text-console character RAM writer with cursor, control codes and clear engine; define CONSOLE_SCROLL_EN to scroll instead of wrapping at end of screen
module console_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        charValid,
  input  logic [7:0]  charData,
  output logic        charReady,
  output logic [12:0] addrWChar,
  output logic [7:0]  dataWChar,
  output logic        writeEnable,
  output logic [6:0]  cursorCol,
  output logic [4:0]  cursorRow,
  output logic [4:0]  rowOffset
);
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR_ROW, CLEAR_ALL} state_t;
  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d, off_q, off_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  chr_q, chr_d;
  logic        adv_q, adv_d, rdy_q, nl, accept;
  logic [5:0]  row_sum;
  logic [4:0]  phys;
  logic [12:0] base;
  assign accept   = charValid && rdy_q;
  assign row_sum  = {1'b0, row_q} + {1'b0, off_q};
  assign phys     = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
  assign base     = (COLS == 80) ? 13'({phys, 6'b0}) + 13'({phys, 4'b0}) : 13'(phys * COLS);
  assign writeEnable = state_q != IDLE;
  assign addrWChar   = state_q == CLEAR_ALL ? {1'b0, cnt_q} :
                       state_q == CLEAR_ROW ? base + 13'(cnt_q) :
                       state_q == WRITE     ? base + 13'(col_q) : '0;
  assign dataWChar   = state_q == WRITE ? chr_q : state_q == IDLE ? '0 : CLEAR_CHAR;
  assign charReady   = rdy_q;
  assign cursorCol   = col_q;
  assign cursorRow   = row_q;
  assign rowOffset   = off_q;
  // next-state: byte decode in IDLE, cursor advance after a glyph, clear counters, shared row advance
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    chr_d   = chr_q;
    adv_d   = adv_q;
    nl      = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (charData == 8'h08) begin
          if (col_q != '0) begin
            col_d   = col_q - 7'd1;
            chr_d   = CLEAR_CHAR;
            adv_d   = 1'b0;
            state_d = WRITE;
          end
        end else if (charData == 8'h0D) begin
          col_d = '0;
        end else if (charData == 8'h0A) begin
          col_d = '0;
          nl    = 1'b1;
        end else if (charData == 8'h0C) begin
          col_d   = '0;
          row_d   = '0;
          off_d   = '0;
          cnt_d   = '0;
          state_d = CLEAR_ALL;
        end else if (charData >= 8'h20 && charData != 8'h7F) begin
          chr_d   = charData;
          adv_d   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (adv_q) begin
          if (col_q == 7'(COLS - 1)) begin
            col_d = '0;
            nl    = 1'b1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
      CLEAR_ROW: begin
        cnt_d   = cnt_q + 12'd1;
        state_d = (cnt_q == 12'(COLS - 1)) ? IDLE : CLEAR_ROW;
      end
      CLEAR_ALL: begin
        cnt_d   = cnt_q + 12'd1;
        state_d = (cnt_q == 12'(COLS * ROWS - 1)) ? IDLE : CLEAR_ALL;
      end
      default: state_d = IDLE;
    endcase
    if (nl) begin
      if (row_q != 5'(ROWS - 1)) begin
        row_d = row_q + 5'd1;
      end else begin
`ifdef CONSOLE_SCROLL_EN
        off_d = (off_q == 5'(ROWS - 1)) ? '0 : off_q + 5'd1;
`else
        row_d = '0;
`endif
        cnt_d   = '0;
        state_d = CLEAR_ROW;
      end
    end
  end
  // state and cursor registers; ready is high exactly when the next state is IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      chr_q   <= '0;
      adv_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      chr_q   <= chr_d;
      adv_q   <= adv_d;
      rdy_q   <= state_d == IDLE;
    end
  end
endmodule

// File: doc/console_writer.md
Name: console_writer

Overview:
- Upstream producer for the text-mode console scan-out stage. Writes into the shared character RAM that the scan-out stage reads via its 13-bit character address.
- Accepts a byte stream over a valid/ready handshake and keeps a cursor.
- Writes printable glyph codes and interprets a small set of control codes: backspace, line feed, carriage return, form feed.
- Handles line wrap, end-of-screen and full-screen clear with a multi-cycle clear engine.

Parameters:
- COLS, 80, text columns per row (640 px / 8 px glyph)
- ROWS, 30, text rows (480 px / 16 px glyph)
- CLEAR_CHAR, 8'h20, fill code used by clears and backspace

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- charValid  in  1  upstream byte valid
- charData  in  8  upstream byte
- charReady  out  1  block can accept a byte this cycle
- addrWChar  out  13  character RAM write address
- dataWChar  out  8  character RAM write data
- writeEnable  out  1  character RAM write strobe, one cycle per cell
- cursorCol  out  7  logical cursor column, 0..COLS-1
- cursorRow  out  5  logical cursor row, 0..ROWS-1
- rowOffset  out  5  physical row shown at screen top; scan-out adds it to its row, mod ROWS

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; charReady=0 while reset is asserted, 1 from the first clk after release.
  - writeEnable=0; addrWChar=0; dataWChar=0.
  - cursorCol=0; cursorRow=0; rowOffset=0.
- Addressing:
  - addrWChar = physRow*COLS + col, with physRow = (cursorRow+rowOffset) mod ROWS.
  - The multiply is done as (r<<6)+(r<<4) for COLS=80.
  - Maximum address is 2399; addresses never exceed COLS*ROWS-1.
- Handshake:
  - A byte is accepted on a rising edge where charValid && charReady.
  - charReady is high only in IDLE and drops the cycle after an accept.
  - While charReady=0, charData/charValid are ignored; upstream must hold them.
- States: IDLE, WRITE, CLEAR_ROW, CLEAR_ALL.
- IDLE, on accept, by code:
  - 0x20..0xFF except 0x7F: go to WRITE.
  - 0x08 BS:
    - col>0: col-=1, then WRITE of CLEAR_CHAR at the new col, with no advance.
    - col==0: no-op, stay IDLE.
  - 0x0D CR: col=0; stay IDLE.
  - 0x0A LF: col=0, then row advance.
  - 0x0C FF: go to CLEAR_ALL.
  - Other 0x00..0x1F and 0x7F: ignored, stay IDLE.
- WRITE:
  - writeEnable=1 for exactly one cycle, on the cycle after the accept, with the cursor-derived address.
  - Printable byte: col+=1. If col was COLS-1, col=0 and row advance.
  - Return to IDLE unless a row advance is pending.
- Row advance:
  - row<ROWS-1: row+=1, go to IDLE.
  - row==ROWS-1: end-of-screen handling (see Optional Feature), then CLEAR_ROW on the new physical row.
- CLEAR_ROW:
  - COLS consecutive cycles with writeEnable=1, dataWChar=CLEAR_CHAR.
  - Column counter runs 0..COLS-1.
  - charReady returns high on the cycle after the last write.
- CLEAR_ALL:
  - Address counter runs 0..COLS*ROWS-1, one write per cycle, CLEAR_CHAR.
  - On entry, cursor and rowOffset are set to 0.
  - Returns to IDLE after address 2399.
- Reset mid-clear: abort immediately. No further writes; the partially cleared RAM is left as is.
- writeEnable is low in IDLE at all times.

Optional Feature:
- Macro: CONSOLE_SCROLL_EN.
- Defined (scroll at end of screen):
  - cursorRow stays ROWS-1.
  - rowOffset increments mod ROWS, changing only on that cycle.
  - The new bottom line is the old top physical row; it is cleared, so the screen scrolls without copying RAM.
- Undefined (wrap at end of screen):
  - cursorRow wraps to 0 and physical row 0 is cleared.
  - rowOffset is tied to 0.

Test Plan:
- Release reset, send 0x41: one writeEnable pulse the cycle after accept, addr 0, data 0x41, cursorCol=1, charReady low for 1 cycle.
- Send 80 bytes of 0x42 then 0x43:
  - last 0x42 at addr 79;
  - cursor (0,1);
  - 0x43 at addr 80.
- Move to row 29 col 5, send 0x0A:
  - exactly 80 writes of 0x20;
  - without CONSOLE_SCROLL_EN: addrs 0..79, cursor (0,0);
  - with CONSOLE_SCROLL_EN: addrs 0..79, rowOffset=1, cursor (0,29); next 0x41 goes to addr 0.
- Send 0x0C after a scroll:
  - 2400 writes of 0x20, addrs 0..2399 in order;
  - charReady low throughout;
  - afterwards cursor (0,0) and rowOffset=0.
- Backspace:
  - at col 0, send 0x08: no write, cursor unchanged.
  - at col 3 row 2, send 0x08: write 0x20 at addr 162, cursorCol=2.
- Assert rst_n low at clear cycle 1000 of a form feed: writeEnable falls asynchronously, all outputs at reset values; a new byte is accepted after release.
